// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Signal bundle between the VGA raster timing generator and its
//               consumers (framebuffer read, DAC/pin logic, run control).
//               master : timing generator (takes en, drives everything else)
//               slave  : consumer side (drives en, observes timing)
// Ports       : en          run enable (0 freezes all timing state)
//               pix_ce      pixel strobe, one vgaclk cycle per pixel
//               hcnt/vcnt   raster position
//               fb_x/fb_y   downscaled framebuffer coordinates
//               hsync/vsync sync outputs at configured polarity
//               sync_b      composite sync (constant 0)
//               blank_b     1 inside the visible region
//               line_start  one-cycle strobe on entry to hcnt=0
//               frame_start one-cycle strobe on entry to (0,0)
//               frame_cnt   completed-frame counter, wraps
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CW       = 10,
    parameter int SCALE_SH = 2,
    parameter int FCW      = 8
);
    logic                   en;
    logic                   pix_ce;
    logic [CW-1:0]          hcnt;
    logic [CW-1:0]          vcnt;
    logic [CW-SCALE_SH-1:0] fb_x;
    logic [CW-SCALE_SH-1:0] fb_y;
    logic                   hsync;
    logic                   vsync;
    logic                   sync_b;
    logic                   blank_b;
    logic                   line_start;
    logic                   frame_start;
    logic [FCW-1:0]         frame_cnt;

    modport master (
        input  en,
        output pix_ce, hcnt, vcnt, fb_x, fb_y, hsync, vsync, sync_b,
               blank_b, line_start, frame_start, frame_cnt
    );

    modport slave (
        output en,
        input  pix_ce, hcnt, vcnt, fb_x, fb_y, hsync, vsync, sync_b,
               blank_b, line_start, frame_start, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator. A pixel-clock
//               divider produces pix_ce; horizontal/vertical counters and a
//               frame counter advance on it. Every decode (syncs, blanking,
//               framebuffer coordinates, strobes) is computed from the
//               next-state counter values and registered alongside the
//               counters, so decodes never lag the counters they describe.
// Ports       : vgaclk   pixel/system clock
//               reset_b  asynchronous active-low reset; assertion is
//                        asynchronous, release must be synchronous to vgaclk
//               vga      vga_timing_gen_if.master (see interface header)
// Constraints : HTOTAL and VTOTAL must each be <= 2**CW; PIXDIV >= 1;
//               SCALE_SH < CW.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int HACTIVE  = 640,
    parameter int HFP      = 16,
    parameter int HSYN     = 96,
    parameter int HBP      = 48,
    parameter int VACTIVE  = 480,
    parameter int VFP      = 10,
    parameter int VSYN     = 2,
    parameter int VBP      = 33,
    parameter int CW       = 10,
    parameter bit HPOL     = 1'b0,
    parameter bit VPOL     = 1'b0,
    parameter int PIXDIV   = 1,
    parameter int SCALE_SH = 2,
    parameter int FCW      = 8
) (
    input  logic                  vgaclk,
    input  logic                  reset_b,
    vga_timing_gen_if.master      vga
);

    localparam int c_HTOTAL = HACTIVE + HFP + HSYN + HBP;
    localparam int c_VTOTAL = VACTIVE + VFP + VSYN + VBP;
    localparam int c_DW     = (PIXDIV > 1) ? $clog2(PIXDIV) : 1;

    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(PIXDIV - 1);
    localparam logic [CW-1:0]   c_H_LAST   = CW'(c_HTOTAL - 1);
    localparam logic [CW-1:0]   c_V_LAST   = CW'(c_VTOTAL - 1);

    // Region boundaries carry one extra bit so that a boundary equal to
    // 2**CW (back porch of zero with a full-range counter) still compares.
    localparam logic [CW:0] c_H_ACT_END = (CW+1)'(HACTIVE);
    localparam logic [CW:0] c_H_SYN_BEG = (CW+1)'(HACTIVE + HFP);
    localparam logic [CW:0] c_H_SYN_END = (CW+1)'(HACTIVE + HFP + HSYN);
    localparam logic [CW:0] c_V_ACT_END = (CW+1)'(VACTIVE);
    localparam logic [CW:0] c_V_SYN_BEG = (CW+1)'(VACTIVE + VFP);
    localparam logic [CW:0] c_V_SYN_END = (CW+1)'(VACTIVE + VFP + VSYN);

    logic [c_DW-1:0]        div_q,    div_d;
    logic [CW-1:0]          hcnt_q,   hcnt_d;
    logic [CW-1:0]          vcnt_q,   vcnt_d;
    logic [FCW-1:0]         frame_q,  frame_d;
    logic                   hsync_q,  hsync_d;
    logic                   vsync_q,  vsync_d;
    logic                   blank_q,  blank_d;
    logic [CW-SCALE_SH-1:0] fbx_q,    fbx_d;
    logic [CW-SCALE_SH-1:0] fby_q,    fby_d;
    logic                   line_q,   line_d;
    logic                   fstart_q, fstart_d;

    logic                   w_pix_ce;
    logic                   w_h_wrap;
    logic                   w_v_wrap;
    logic [CW:0]            w_hx;
    logic [CW:0]            w_vx;

    // pix_ce is combinational; gating with reset_b keeps it low while the
    // design is held in reset even if en is already high.
    assign w_pix_ce = reset_b & vga.en & (div_q == c_DIV_LAST);
    assign w_h_wrap = w_pix_ce & (hcnt_q == c_H_LAST);
    assign w_v_wrap = w_h_wrap & (vcnt_q == c_V_LAST);

    always_comb begin
        div_d = div_q;
        if (vga.en) begin
            div_d = (div_q == c_DIV_LAST) ? '0 : div_q + 1'b1;
        end

        hcnt_d = hcnt_q;
        if (w_pix_ce) begin
            hcnt_d = w_h_wrap ? '0 : hcnt_q + 1'b1;
        end

        vcnt_d = vcnt_q;
        if (w_h_wrap) begin
            vcnt_d = w_v_wrap ? '0 : vcnt_q + 1'b1;
        end

        frame_d = frame_q;
        if (w_v_wrap) begin
            frame_d = frame_q + 1'b1;
        end

        // Decode the values the counters are about to take, so the
        // registered decodes line up with the registered counters.
        w_hx = {1'b0, hcnt_d};
        w_vx = {1'b0, vcnt_d};

        hsync_d  = ((w_hx >= c_H_SYN_BEG) && (w_hx < c_H_SYN_END)) ? HPOL : ~HPOL;
        vsync_d  = ((w_vx >= c_V_SYN_BEG) && (w_vx < c_V_SYN_END)) ? VPOL : ~VPOL;
        blank_d  = (w_hx < c_H_ACT_END) && (w_vx < c_V_ACT_END);
        fbx_d    = hcnt_d[CW-1:SCALE_SH];
        fby_d    = vcnt_d[CW-1:SCALE_SH];

        // Strobes come from the wrap event itself, not from the counter
        // being zero, so they fire once per wrap regardless of PIXDIV or
        // pauses, and never for the post-reset origin.
        line_d   = w_h_wrap;
        fstart_d = w_v_wrap;
    end

    always_ff @(posedge vgaclk or negedge reset_b) begin
        if (!reset_b) begin
            div_q    <= '0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            frame_q  <= '0;
            hsync_q  <= ~HPOL;
            vsync_q  <= ~VPOL;
            blank_q  <= 1'b1;
            fbx_q    <= '0;
            fby_q    <= '0;
            line_q   <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            frame_q  <= frame_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
            fbx_q    <= fbx_d;
            fby_q    <= fby_d;
            line_q   <= line_d;
            fstart_q <= fstart_d;
        end
    end

    assign vga.pix_ce      = w_pix_ce;
    assign vga.hcnt        = hcnt_q;
    assign vga.vcnt        = vcnt_q;
    assign vga.fb_x        = fbx_q;
    assign vga.fb_y        = fby_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.sync_b      = 1'b0;
    assign vga.blank_b     = blank_q;
    assign vga.line_start  = line_q;
    assign vga.frame_start = fstart_q;
    assign vga.frame_cnt   = frame_q;

endmodule
`default_nettype wire
